// File: rtl/zbus_fifo_reg_sync_pkg.sv
// rtl/zbus_fifo_reg_sync_pkg.sv - shared zbus handshake definitions and sizing helper
package zbus_fifo_reg_sync_pkg;

  typedef struct packed {
    logic vld;
    logic ack;
  } zbus_hs_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A word moves on an edge only when both sides agree.
  function automatic logic zbus_trn(input zbus_hs_t hs);
    return hs.vld & hs.ack;
  endfunction

endpackage

// File: rtl/zbus_fifo_mem.sv
// rtl/zbus_fifo_mem.sv - LN x BW register array, synchronous write, asynchronous read
module zbus_fifo_mem
  import zbus_fifo_reg_sync_pkg::*;
#(
  parameter int BW = 8,
  parameter int LN = 4,
  localparam int AW = clog2(LN)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [BW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [BW-1:0] o_rdata
);

  logic [BW-1:0] r_mem [LN];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/zbus_fifo_reg_sync.sv
// rtl/zbus_fifo_reg_sync.sv - single-clock zbus register FIFO with flush, count, flags, fall-through
module zbus_fifo_reg_sync
  import zbus_fifo_reg_sync_pkg::*;
#(
  parameter int BW = 8,
  parameter int LN = 4,
  parameter int AF = LN - 1,
  parameter int AE = 1,
  parameter int FT = 0,
  localparam int CW = clog2(LN + 1)
) (
  input  logic          z_clk,
  input  logic          z_rst,
  input  logic          z_clr,
  input  logic          zi_vld,
  input  logic [BW-1:0] zi_bus,
  output logic          zi_ack,
  output logic          zo_vld,
  output logic [BW-1:0] zo_bus,
  input  logic          zo_ack,
  output logic [CW-1:0] z_cnt,
  output logic          z_afl,
  output logic          z_aem
);

  localparam int            PW     = clog2(LN);
  localparam logic [PW-1:0] P_LAST = PW'(LN - 1);
  localparam logic [CW-1:0] C_FULL = CW'(LN);
  localparam logic [CW-1:0] C_AF   = CW'(AF);
  localparam logic [CW-1:0] C_AE   = CW'(AE);
  localparam logic          B_FT   = (FT != 0);

  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  logic [BW-1:0] w_rd_data;
  logic          w_live;
  logic          w_empty;
  logic          w_full;
  logic          w_ft_empty;
  zbus_hs_t      w_zi_hs;
  zbus_hs_t      w_zo_hs;
  logic          w_zi_trn;
  logic          w_zo_trn;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_live     = ~z_rst & ~z_clr;
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == C_FULL);
  assign w_ft_empty = B_FT & w_empty;

  assign zi_ack = w_live & ~w_full;
  assign zo_vld = w_ft_empty ? (zi_vld & w_live) : (w_live & ~w_empty);
  assign zo_bus = w_ft_empty ? zi_bus : w_rd_data;

  assign w_zi_hs  = {zi_vld, zi_ack};
  assign w_zo_hs  = {zo_vld, zo_ack};
  assign w_zi_trn = zbus_trn(w_zi_hs);
  assign w_zo_trn = zbus_trn(w_zo_hs);

  // An empty fall-through FIFO whose output is taken hands the word straight
  // across; storage and pointers are left untouched.
  assign w_bypass = w_ft_empty & w_zo_trn;
  assign w_push   = w_zi_trn & ~w_bypass;
  assign w_pop    = w_zo_trn & ~w_bypass;

  always_ff @(posedge z_clk) begin
    if (z_rst || z_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= ptr_next(r_wp);
      end
      if (w_pop) begin
        r_rp <= ptr_next(r_rp);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  zbus_fifo_mem #(
    .BW(BW),
    .LN(LN)
  ) u_mem (
    .i_clk   (z_clk),
    .i_we    (w_push),
    .i_waddr (r_wp),
    .i_wdata (zi_bus),
    .i_raddr (r_rp),
    .o_rdata (w_rd_data)
  );

  assign z_cnt = r_cnt;
  assign z_afl = (r_cnt >= C_AF);
  assign z_aem = (r_cnt <= C_AE);

endmodule
